screen_blitter: RTL and testbench

SCREEN_BLITTER -- requirements
Module: screen_blitter

---
 rtl/screen_blitter_if.sv | 40 ++++
 rtl/screen_blitter.sv | 141 ++++++++++++++
 tb/tb_screen_blitter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/screen_blitter_if.sv
// Bus bundle for screen_blitter: region request/handshake, per-pixel logic hook,
// framebuffer read port and vga_adapter plot port.
interface screen_blitter_if #(
    parameter int WIDTH        = 8,
    parameter int COLOUR_WIDTH = 3
);
    logic                    screen_start;
    logic [WIDTH-1:0]        screen_x_min;
    logic [WIDTH-1:0]        screen_y_min;
    logic [WIDTH-1:0]        screen_x_range;
    logic [WIDTH-1:0]        screen_y_range;
    logic [COLOUR_WIDTH-1:0] new_screen_colour;
    logic [WIDTH-1:0]        screen_x;
    logic [WIDTH-1:0]        screen_y;
    logic [COLOUR_WIDTH-1:0] old_screen_colour;
    logic                    screen_done;
    logic                    busy;
    logic                    fb_rd_en;
    logic [WIDTH-1:0]        fb_rd_x;
    logic [WIDTH-1:0]        fb_rd_y;
    logic [COLOUR_WIDTH-1:0] fb_rd_data;
    logic                    plot;
    logic [WIDTH-1:0]        plot_x;
    logic [WIDTH-1:0]        plot_y;
    logic [COLOUR_WIDTH-1:0] plot_colour;

    modport master (
        input  screen_start, screen_x_min, screen_y_min, screen_x_range, screen_y_range,
        input  new_screen_colour, fb_rd_data,
        output screen_x, screen_y, old_screen_colour, screen_done, busy,
        output fb_rd_en, fb_rd_x, fb_rd_y, plot, plot_x, plot_y, plot_colour
    );

    modport slave (
        output screen_start, screen_x_min, screen_y_min, screen_x_range, screen_y_range,
        output new_screen_colour, fb_rd_data,
        input  screen_x, screen_y, old_screen_colour, screen_done, busy,
        input  fb_rd_en, fb_rd_x, fb_rd_y, plot, plot_x, plot_y, plot_colour
    );
endinterface

// File: rtl/screen_blitter.sv
// Raster-scans a rectangular region: reads each pixel, presents it to external logic,
// and plots the returned colour. Optional clipping via `SCREEN_BLITTER_CLIP_EN.
module screen_blitter #(
    parameter int WIDTH        = 8,
    parameter int COLOUR_WIDTH = 3,
    parameter int SCREEN_W     = 160,
    parameter int SCREEN_H     = 120,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              resetn,
    screen_blitter_if.master  bus
);
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("screen_blitter: READ_LATENCY must be 1..4");
    end
    if (SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_screen
        $error("screen_blitter: SCREEN_W/SCREEN_H must be positive");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0] x_min_q, y_min_q, x_rng_q, y_rng_q;
    logic [WIDTH-1:0] cx, cy;
    logic [WIDTH-1:0] rd_x, rd_y;
    logic             in_screen, rd_en, slot_last, issue_last;
    logic             start_ok, done_q;

    logic [READ_LATENCY-1:0]            pipe_v, pipe_last;
    logic [READ_LATENCY-1:0][WIDTH-1:0] pipe_x, pipe_y;
    logic                               pres;
    logic [WIDTH-1:0]                   hold_x, hold_y;
    logic [COLOUR_WIDTH-1:0]            hold_c;

    assign start_ok   = bus.screen_start && (state == IDLE) && !done_q;
    assign slot_last  = (cx == x_rng_q) && (cy == y_rng_q);
    assign issue_last = (state == RUN) && slot_last;

`ifdef SCREEN_BLITTER_CLIP_EN
    localparam logic [31:0] SCR_W = SCREEN_W;
    localparam logic [31:0] SCR_H = SCREEN_H;
    logic [WIDTH:0] sum_x, sum_y;
    assign sum_x     = {1'b0, x_min_q} + {1'b0, cx};
    assign sum_y     = {1'b0, y_min_q} + {1'b0, cy};
    assign rd_x      = sum_x[WIDTH-1:0];
    assign rd_y      = sum_y[WIDTH-1:0];
    assign in_screen = !sum_x[WIDTH] && !sum_y[WIDTH] &&
                       (32'(sum_x) < SCR_W) && (32'(sum_y) < SCR_H);
`else
    assign rd_x      = x_min_q + cx;
    assign rd_y      = y_min_q + cy;
    assign in_screen = 1'b1;
`endif

    assign rd_en = (state == RUN) && in_screen;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (slot_last) state_next = DRAIN;
            DRAIN:   if (pipe_last[READ_LATENCY-1]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_min_q <= '0;
            y_min_q <= '0;
            x_rng_q <= '0;
            y_rng_q <= '0;
            cx      <= '0;
            cy      <= '0;
        end else if (start_ok) begin
            x_min_q <= bus.screen_x_min;
            y_min_q <= bus.screen_y_min;
            x_rng_q <= bus.screen_x_range;
            y_rng_q <= bus.screen_y_range;
            cx      <= '0;
            cy      <= '0;
        end else if (state == RUN && !slot_last) begin
            if (cx == x_rng_q) begin
                cx <= '0;
                cy <= cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

    // Slot marker travels alongside read-valid so clipped slots still time the drain.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pipe_v    <= '0;
            pipe_last <= '0;
            pipe_x    <= '0;
            pipe_y    <= '0;
            done_q    <= 1'b0;
        end else begin
            pipe_v    <= READ_LATENCY'({pipe_v, rd_en});
            pipe_last <= READ_LATENCY'({pipe_last, issue_last});
            pipe_x    <= (READ_LATENCY*WIDTH)'({pipe_x, rd_x});
            pipe_y    <= (READ_LATENCY*WIDTH)'({pipe_y, rd_y});
            done_q    <= (state == DRAIN) && pipe_last[READ_LATENCY-1];
        end
    end

    assign pres = pipe_v[READ_LATENCY-1];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hold_x <= '0;
            hold_y <= '0;
            hold_c <= '0;
        end else if (pres) begin
            hold_x <= pipe_x[READ_LATENCY-1];
            hold_y <= pipe_y[READ_LATENCY-1];
            hold_c <= bus.fb_rd_data;
        end
    end

    assign bus.screen_x          = pres ? pipe_x[READ_LATENCY-1] : hold_x;
    assign bus.screen_y          = pres ? pipe_y[READ_LATENCY-1] : hold_y;
    assign bus.old_screen_colour = pres ? bus.fb_rd_data : hold_c;
    assign bus.plot              = pres;
    assign bus.plot_x            = pres ? pipe_x[READ_LATENCY-1] : hold_x;
    assign bus.plot_y            = pres ? pipe_y[READ_LATENCY-1] : hold_y;
    assign bus.plot_colour       = pres ? bus.new_screen_colour : '0;
    assign bus.screen_done       = done_q;
    assign bus.busy              = (state != IDLE);
    assign bus.fb_rd_en          = rd_en;
    assign bus.fb_rd_x           = rd_x;
    assign bus.fb_rd_y           = rd_y;
endmodule

// File: tb/tb_screen_blitter.sv
// Directed bench for screen_blitter: one instance at READ_LATENCY=1, one at 3,
// framebuffer models with matching latency, logic hook returns old colour + 1.
module tb_screen_blitter;
    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    screen_blitter_if #(.WIDTH(8), .COLOUR_WIDTH(3)) bus1 ();
    screen_blitter_if #(.WIDTH(8), .COLOUR_WIDTH(3)) bus3 ();

    screen_blitter #(.WIDTH(8), .COLOUR_WIDTH(3), .SCREEN_W(160), .SCREEN_H(120), .READ_LATENCY(1))
        dut1 (.clock(clock), .resetn(resetn), .bus(bus1));
    screen_blitter #(.WIDTH(8), .COLOUR_WIDTH(3), .SCREEN_W(160), .SCREEN_H(120), .READ_LATENCY(3))
        dut3 (.clock(clock), .resetn(resetn), .bus(bus3));

    logic [2:0] fb_mem [65536];
    logic [2:0] fb1_d, fb3_a, fb3_b, fb3_c;
    always @(posedge clock) begin
        fb1_d <= fb_mem[{bus1.fb_rd_y, bus1.fb_rd_x}];
        fb3_a <= fb_mem[{bus3.fb_rd_y, bus3.fb_rd_x}];
        fb3_b <= fb3_a;
        fb3_c <= fb3_b;
    end
    assign bus1.fb_rd_data        = fb1_d;
    assign bus3.fb_rd_data        = fb3_c;
    assign bus1.new_screen_colour = bus1.old_screen_colour + 3'd1;
    assign bus3.new_screen_colour = bus3.old_screen_colour + 3'd1;

    typedef struct {
        int         cyc;
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] col;
        logic [2:0] old;
    } plot_t;
    plot_t pq1[$], pq3[$];
    int    dq1[$], dq3[$];

    always @(negedge clock) begin
        if (bus1.plot === 1'b1)
            pq1.push_back('{cyc, bus1.plot_x, bus1.plot_y, bus1.plot_colour, bus1.old_screen_colour});
        if (bus3.plot === 1'b1)
            pq3.push_back('{cyc, bus3.plot_x, bus3.plot_y, bus3.plot_colour, bus3.old_screen_colour});
        if (bus1.screen_done === 1'b1) dq1.push_back(cyc);
        if (bus3.screen_done === 1'b1) dq3.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_plot(input string tag, input int sel, input int idx, input int exp_cyc,
                            input logic [7:0] ex, input logic [7:0] ey,
                            input logic [2:0] ecol, input logic [2:0] eold);
        plot_t p;
        int    n;
        string t;
        t = $sformatf("%s_p%0d", tag, idx);
        n = (sel == 1) ? pq1.size() : pq3.size();
        chk({t, "_present"}, 32'(idx < n), 32'd1);
        if (idx < n) begin
            if (sel == 1) p = pq1[idx];
            else          p = pq3[idx];
            chk({t, "_cyc"}, p.cyc, exp_cyc);
            chk({t, "_x"},   p.x,   ex);
            chk({t, "_y"},   p.y,   ey);
            chk({t, "_col"}, p.col, ecol);
            chk({t, "_old"}, p.old, eold);
        end
    endtask

    task automatic chk_done(input string tag, input int sel, input int exp_cyc);
        int n;
        n = (sel == 1) ? dq1.size() : dq3.size();
        chk({tag, "_done_count"}, n, 1);
        if (n >= 1) chk({tag, "_done_cyc"}, (sel == 1) ? dq1[0] : dq3[0], exp_cyc);
    endtask

    task automatic do_start(input int sel, input logic [7:0] xm, input logic [7:0] ym,
                            input logic [7:0] xr, input logic [7:0] yr, output int st);
        @(negedge clock);
        pq1.delete(); dq1.delete(); pq3.delete(); dq3.delete();
        if (sel == 1) begin
            bus1.screen_x_min = xm; bus1.screen_y_min = ym;
            bus1.screen_x_range = xr; bus1.screen_y_range = yr;
            bus1.screen_start = 1'b1;
        end else begin
            bus3.screen_x_min = xm; bus3.screen_y_min = ym;
            bus3.screen_x_range = xr; bus3.screen_y_range = yr;
            bus3.screen_start = 1'b1;
        end
        st = cyc;
        @(negedge clock);
        bus1.screen_start = 1'b0;
        bus3.screen_start = 1'b0;
    endtask

    initial begin
        int st;
        bus1.screen_start = 1'b0; bus1.screen_x_min = '0; bus1.screen_y_min = '0;
        bus1.screen_x_range = '0; bus1.screen_y_range = '0;
        bus3.screen_start = 1'b0; bus3.screen_x_min = '0; bus3.screen_y_min = '0;
        bus3.screen_x_range = '0; bus3.screen_y_range = '0;
        for (int i = 0; i < 65536; i++) fb_mem[i] = 3'd3;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_plot",   bus1.plot, 0);
        chk("rst_busy",   bus1.busy, 0);
        chk("rst_done",   bus1.screen_done, 0);
        chk("rst_rd_en",  bus1.fb_rd_en, 0);
        chk("rst_sx",     bus1.screen_x, 0);
        chk("rst_sy",     bus1.screen_y, 0);
        chk("rst_old",    bus1.old_screen_colour, 0);
        chk("rst_pcol",   bus1.plot_colour, 0);
        chk("rst_busy3",  bus3.busy, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // single pixel at (5,7)
        do_start(1, 8'd5, 8'd7, 8'd0, 8'd0, st);
        chk("single_busy",  bus1.busy, 1);
        chk("single_rd_en", bus1.fb_rd_en, 1);
        chk("single_rd_x",  bus1.fb_rd_x, 5);
        chk("single_rd_y",  bus1.fb_rd_y, 7);
        repeat (10) @(negedge clock);
        chk("single_count", pq1.size(), 1);
        chk_plot("single", 1, 0, st + 2, 8'd5, 8'd7, 3'd4, 3'd3);
        chk_done("single", 1, st + 3);
        chk("hold_plot", bus1.plot, 0);
        chk("hold_sx",   bus1.screen_x, 5);
        chk("hold_sy",   bus1.screen_y, 7);
        chk("hold_old",  bus1.old_screen_colour, 3);
        chk("hold_busy", bus1.busy, 0);

        // 3x2 raster order
        do_start(1, 8'd0, 8'd0, 8'd2, 8'd1, st);
        repeat (12) @(negedge clock);
        chk("r32_count", pq1.size(), 6);
        for (int i = 0; i < 6; i++)
            chk_plot("r32", 1, i, st + 2 + i, 8'(i % 3), 8'(i / 3), 3'd4, 3'd3);
        chk_done("r32", 1, st + 8);

        // start re-pulsed in the third RUN cycle is ignored
        do_start(1, 8'd0, 8'd0, 8'd2, 8'd1, st);
        repeat (2) @(negedge clock);
        bus1.screen_start = 1'b1;
        @(negedge clock);
        bus1.screen_start = 1'b0;
        repeat (12) @(negedge clock);
        chk("restart_count", pq1.size(), 6);
        chk_plot("restart", 1, 5, st + 7, 8'd2, 8'd1, 3'd4, 3'd3);
        chk_done("restart", 1, st + 8);

        // start coinciding with screen_done is ignored
        do_start(1, 8'd1, 8'd1, 8'd0, 8'd0, st);
        repeat (2) @(negedge clock);
        chk("startdone_done", bus1.screen_done, 1);
        bus1.screen_start = 1'b1;
        @(negedge clock);
        bus1.screen_start = 1'b0;
        chk("startdone_busy", bus1.busy, 0);
        repeat (10) @(negedge clock);
        chk("startdone_count", pq1.size(), 1);
        chk_done("startdone", 1, st + 3);

        // reset in the middle of a 4x4 pass
        do_start(1, 8'd10, 8'd10, 8'd3, 8'd3, st);
        repeat (5) @(negedge clock);
        chk("midrst_plot_before", bus1.plot, 1);
        resetn = 1'b0;
        #1;
        chk("midrst_plot", bus1.plot, 0);
        chk("midrst_busy", bus1.busy, 0);
        chk("midrst_rd_en", bus1.fb_rd_en, 0);
        pq1.delete(); dq1.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (25) @(negedge clock);
        chk("midrst_no_plot", pq1.size(), 0);
        chk("midrst_no_done", dq1.size(), 0);
        do_start(1, 8'd10, 8'd10, 8'd1, 8'd1, st);
        repeat (10) @(negedge clock);
        chk("after_rst_count", pq1.size(), 4);
        chk_plot("after_rst", 1, 0, st + 2, 8'd10, 8'd10, 3'd4, 3'd3);
        chk_plot("after_rst", 1, 3, st + 5, 8'd11, 8'd11, 3'd4, 3'd3);
        chk_done("after_rst", 1, st + 6);

        // right screen edge
        do_start(1, 8'd158, 8'd0, 8'd3, 8'd0, st);
        repeat (10) @(negedge clock);
`ifdef SCREEN_BLITTER_CLIP_EN
        chk("edge_count", pq1.size(), 2);
        for (int i = 0; i < 2; i++)
            chk_plot("edge", 1, i, st + 2 + i, 8'(158 + i), 8'd0, 3'd4, 3'd3);
`else
        chk("edge_count", pq1.size(), 4);
        for (int i = 0; i < 4; i++)
            chk_plot("edge", 1, i, st + 2 + i, 8'(158 + i), 8'd0, 3'd4, 3'd3);
`endif
        chk_done("edge", 1, st + 6);

        // coordinate wrap past 255
        do_start(1, 8'd254, 8'd5, 8'd3, 8'd0, st);
        repeat (10) @(negedge clock);
`ifdef SCREEN_BLITTER_CLIP_EN
        chk("wrap_count", pq1.size(), 0);
`else
        chk("wrap_count", pq1.size(), 4);
        chk_plot("wrap", 1, 1, st + 3, 8'd255, 8'd5, 3'd4, 3'd3);
        chk_plot("wrap", 1, 2, st + 4, 8'd0,   8'd5, 3'd4, 3'd3);
        chk_plot("wrap", 1, 3, st + 5, 8'd1,   8'd5, 3'd4, 3'd3);
`endif
        chk_done("wrap", 1, st + 6);

        // READ_LATENCY=3 with distinct framebuffer contents
        fb_mem[{8'd30, 8'd20}] = 3'd5;
        fb_mem[{8'd30, 8'd21}] = 3'd6;
        do_start(3, 8'd20, 8'd30, 8'd1, 8'd0, st);
        repeat (10) @(negedge clock);
        chk("lat3_count", pq3.size(), 2);
        chk_plot("lat3", 3, 0, st + 4, 8'd20, 8'd30, 3'd6, 3'd5);
        chk_plot("lat3", 3, 1, st + 5, 8'd21, 8'd30, 3'd7, 3'd6);
        chk_done("lat3", 3, st + 6);
        chk("lat3_dut1_idle", dq1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
